bmain_arb: RTL and testbench

Round-robin master arbiter in front of the main bus master port. It accepts command, write-data and read-data channels from N_MASTERS requesters (fetch, memory, DMA, debug) and serialises them onto the single bus_main master interface. Exactly one transaction is in flight at a time. The grant is held from the command beat until the last data beat, and the winner is chosen fairly by round-robin. It also runs a per-transaction watchdog that flags a hung slave.

---
 rtl/bmain_pkg.sv | 13 +
 rtl/bmain_arb_rr_pick.sv | 15 +
 rtl/bmain_arb.sv | 141 ++++++++++++++
 tb/tb_bmain_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bmain_pkg.sv
// bmain_pkg: shared state, command and beat definitions for bus_main and its masters
package bmain_pkg;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
  localparam logic CMD_READ = 1'b1;
  localparam logic CMD_WRITE = 1'b0;
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
  typedef struct packed {
    logic cmd;
    logic [ADDR_W-1:0] addr;
  } bus_beat_t;
endpackage

// File: rtl/bmain_arb_rr_pick.sv
// rr_pick: one-hot round-robin pick of the first requester strictly after last
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] grant
);
  logic [N-1:0] above, req_hi;
  always_comb begin
    above = ~((last << 1) - N'(1));
    req_hi = req & above;
    grant = (|req_hi) ? (req_hi & (~req_hi + N'(1))) : (req & (~req + N'(1)));
  end
endmodule

// File: rtl/bmain_arb.sv
// bmain_arb: round-robin master arbiter with one transaction in flight and a hang watchdog
module bmain_arb
  import bmain_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk_core,
  input  logic                        reset_n,
  input  logic [N_MASTERS-1:0]        m_cvalid,
  output logic [N_MASTERS-1:0]        m_cready,
  input  logic [N_MASTERS-1:0]        m_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS-1:0]        m_wvalid,
  output logic [N_MASTERS-1:0]        m_wready,
  input  logic [N_MASTERS-1:0]        m_wlast,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS*MASK_W-1:0] m_wmask,
  output logic [N_MASTERS-1:0]        m_rvalid,
  input  logic [N_MASTERS-1:0]        m_rready,
  output logic                        m_rlast,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        arb_cvalid,
  output logic                        arb_cmd,
  output logic [ADDR_W-1:0]           arb_addr,
  input  logic                        bmain_cready,
  output logic                        arb_wvalid,
  output logic                        arb_wlast,
  output logic [DATA_W-1:0]           arb_wdata,
  output logic [MASK_W-1:0]           arb_wmask,
  input  logic                        bmain_wready,
  input  logic                        bmain_rvalid,
  input  logic                        bmain_rlast,
  input  logic [DATA_W-1:0]           bmain_rdata,
  output logic                        arb_rready,
  output logic [N_MASTERS-1:0]        arb_grant,
  output logic                        arb_hang
);
  localparam logic [N_MASTERS-1:0] LAST_RST = {1'b1, {(N_MASTERS-1){1'b0}}};
  state_t state, state_nx;
  logic [N_MASTERS-1:0] grant, grant_nx, last_grant, last_nx, pick;
  logic [15:0] wd;
  logic hang_q, hang_now;
  bus_beat_t beat;
  logic g_cvalid, g_wvalid, g_wlast, g_rready;
  logic [DATA_W-1:0] g_wdata;
  logic [MASK_W-1:0] g_wmask;
  logic in_cmd, in_w, in_r;

  rr_pick #(.N(N_MASTERS)) u_pick (
    .req  (m_cvalid),
    .last (last_grant),
    .grant(pick)
  );

  always_comb begin
    beat = '0;
    g_cvalid = 1'b0;
    g_wvalid = 1'b0;
    g_wlast = 1'b0;
    g_rready = 1'b0;
    g_wdata = '0;
    g_wmask = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant[i]) begin
        beat.cmd = m_cmd[i];
        beat.addr = m_addr[i*ADDR_W +: ADDR_W];
        g_cvalid = m_cvalid[i];
        g_wvalid = m_wvalid[i];
        g_wlast = m_wlast[i];
        g_rready = m_rready[i];
        g_wdata = m_wdata[i*DATA_W +: DATA_W];
        g_wmask = m_wmask[i*MASK_W +: MASK_W];
      end
    end
  end

  always_comb begin
    in_cmd = state == CMD;
    in_w = state == WDATA;
    in_r = state == RDATA;
    arb_cvalid = in_cmd & g_cvalid;
    arb_cmd = beat.cmd;
    arb_addr = beat.addr;
    m_cready = (in_cmd & bmain_cready) ? grant : '0;
    arb_wvalid = in_w & g_wvalid;
    arb_wlast = g_wlast;
    arb_wdata = g_wdata;
    arb_wmask = g_wmask;
    m_wready = (in_w & bmain_wready) ? grant : '0;
    m_rvalid = (in_r & bmain_rvalid) ? grant : '0;
    arb_rready = in_r & g_rready;
    m_rlast = bmain_rlast;
    m_rdata = bmain_rdata;
    arb_grant = grant;
    hang_now = (state != IDLE) && (wd == 16'(TIMEOUT));
    arb_hang = hang_q | hang_now;
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx = last_grant;
    case (state)
      IDLE: if (|m_cvalid) begin
        state_nx = CMD;
        grant_nx = pick;
      end
      CMD: if (arb_cvalid && bmain_cready)
        state_nx = (beat.cmd == CMD_READ) ? RDATA : WDATA;
      WDATA: if (arb_wvalid && bmain_wready && g_wlast) begin
        state_nx = IDLE;
        grant_nx = '0;
        last_nx = grant;
      end
      RDATA: if (bmain_rvalid && arb_rready && bmain_rlast) begin
        state_nx = IDLE;
        grant_nx = '0;
        last_nx = grant;
      end
      default: state_nx = IDLE;
    endcase
  end

  // counter sits at 0 in IDLE, so it reads 0 on the first CMD cycle
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= LAST_RST;
      wd <= '0;
      hang_q <= 1'b0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last_grant <= last_nx;
      wd <= (state == IDLE) ? '0 : (&wd ? wd : wd + 16'd1);
      hang_q <= arb_hang;
    end
  end
endmodule

// File: tb/tb_bmain_arb.sv
// tb_bmain_arb: directed scoreboard bench for the round-robin bus_main arbiter
module tb_bmain_arb;
  localparam int N = 3;
  logic clk_core = 0, reset_n = 0;
  logic [N-1:0] m_cvalid = '0, m_cready, m_cmd = '0, m_wvalid = '0, m_wready, m_wlast = '0;
  logic [N-1:0] m_rvalid, m_rready = '0, arb_grant;
  logic [N*27-1:0] m_addr = '0;
  logic [N*32-1:0] m_wdata = '0;
  logic [N*4-1:0] m_wmask = '0;
  logic m_rlast, arb_cvalid, arb_cmd, arb_wvalid, arb_wlast, arb_rready, arb_hang;
  logic [31:0] m_rdata, arb_wdata;
  logic [26:0] arb_addr;
  logic [3:0] arb_wmask;
  logic bmain_cready = 0, bmain_wready = 0, bmain_rvalid = 0, bmain_rlast = 0;
  logic [31:0] bmain_rdata = '0;
  int n_vec = 0, n_bad = 0, bad_wready = 0, bad_rr = 0;
  logic [30:0] cq[$];
  logic [39:0] wq[$];
  logic [35:0] rq[$];

  bmain_arb #(.N_MASTERS(N), .TIMEOUT(16)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .m_cvalid(m_cvalid), .m_cready(m_cready), .m_cmd(m_cmd), .m_addr(m_addr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .arb_cvalid(arb_cvalid), .arb_cmd(arb_cmd), .arb_addr(arb_addr), .bmain_cready(bmain_cready),
    .arb_wvalid(arb_wvalid), .arb_wlast(arb_wlast), .arb_wdata(arb_wdata), .arb_wmask(arb_wmask),
    .bmain_wready(bmain_wready), .bmain_rvalid(bmain_rvalid), .bmain_rlast(bmain_rlast),
    .bmain_rdata(bmain_rdata), .arb_rready(arb_rready), .arb_grant(arb_grant), .arb_hang(arb_hang)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: DUT beat with no expected entry", nm);
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    m_cvalid = '0; m_wvalid = '0; m_wlast = '0; m_rready = '0;
    bmain_cready = 0; bmain_wready = 0; bmain_rvalid = 0; bmain_rlast = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic set_c(input int m, input logic cmd, input logic [26:0] a);
    m_cvalid[m] = 1'b1;
    m_cmd[m] = cmd;
    m_addr[m*27 +: 27] = a;
  endtask

  task automatic set_w(input int m, input logic [31:0] d, input logic [3:0] k, input logic l);
    m_wvalid[m] = 1'b1;
    m_wdata[m*32 +: 32] = d;
    m_wmask[m*4 +: 4] = k;
    m_wlast[m] = l;
  endtask

  // monitor: every handshake the DUT presents is matched against the queues
  always @(negedge clk_core) if (reset_n) begin
    if ((m_wready & ~arb_grant) != '0) bad_wready++;
    if (arb_rready && (m_rready & arb_grant) == '0) bad_rr++;
    if (arb_cvalid && bmain_cready) begin
      if (cq.size() == 0) miss("cmd_beat");
      else chk("cmd_beat", {arb_grant, arb_cmd, arb_addr}, cq.pop_front());
    end
    if (arb_wvalid && bmain_wready) begin
      if (wq.size() == 0) miss("wr_beat");
      else chk("wr_beat", {m_wready, arb_wdata, arb_wmask, arb_wlast}, wq.pop_front());
    end
    if ((m_rvalid & m_rready) != '0) begin
      if (rq.size() == 0) miss("rd_beat");
      else chk("rd_beat", {m_rvalid & m_rready, m_rdata, m_rlast}, rq.pop_front());
    end
  end

  initial begin
    int beat;
    logic done, cb, hs;
    do_reset();
    chk("reset_outs", {arb_grant, arb_cvalid, arb_wvalid, arb_rready, m_cready, m_wready, m_rvalid, arb_hang}, 0);

    // single read by master 1 of byte 0x100 (word 0x40)
    set_c(1, 1, 27'h40);
    m_rready[1] = 1; bmain_cready = 1;
    cq.push_back({3'b010, 1'b1, 27'h40});
    chk("t1_idle", arb_grant, 0);
    tick();
    chk("t1_grant", arb_grant, 3'b010);
    chk("t1_cvalid", arb_cvalid, 1);
    tick();
    m_cvalid[1] = 0;
    bmain_rvalid = 1; bmain_rlast = 1; bmain_rdata = 32'hDEADBEEF;
    rq.push_back({3'b010, 32'hDEADBEEF, 1'b1});
    tick();
    bmain_rvalid = 0;
    chk("t1_back_idle", arb_grant, 0);

    // all three masters requesting single-beat reads continuously
    do_reset();
    for (int m = 0; m < N; m++) set_c(m, 1, 27'h10 + 27'(m));
    m_rready = '1; bmain_cready = 1;
    bmain_rvalid = 1; bmain_rlast = 1; bmain_rdata = 32'h0000_0B0B;
    for (int k = 0; k < 4; k++) begin
      cq.push_back({3'(1 << (k % 3)), 1'b1, 27'h10 + 27'(k % 3)});
      rq.push_back({3'(1 << (k % 3)), 32'h0000_0B0B, 1'b1});
    end
    for (int c = 0; c < 11; c++) tick();
    m_cvalid = '0;
    tick();
    bmain_rvalid = 0;
    chk("t2_idle", arb_grant, 0);
    chk("t2_cq_drained", cq.size(), 0);

    // master 2 four-beat write with bmain_wready toggling
    do_reset();
    set_c(2, 0, 27'h123);
    bmain_cready = 1; bmain_wready = 1;
    cq.push_back({3'b100, 1'b0, 27'h123});
    for (int i = 0; i < 4; i++) wq.push_back({3'b100, 32'hA0 + 32'(i), 4'hF, i == 3});
    beat = 0;
    done = 0;
    set_w(2, 32'hA0, 4'hF, 0);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_core);
      cb = m_cready[2] & m_cvalid[2];
      hs = m_wvalid[2] & m_wready[2];
      tick();
      if (cb) m_cvalid[2] = 0;
      if (hs) begin
        if (beat == 3) begin
          m_wvalid[2] = 0;
          done = 1;
        end else begin
          beat++;
          set_w(2, 32'hA0 + 32'(beat), 4'hF, beat == 3);
        end
      end
      bmain_wready = ~bmain_wready;
    end
    chk("t3_done", done, 1);
    chk("t3_idle", arb_grant, 0);
    chk("t3_wq_drained", wq.size(), 0);
    chk("t3_stray_wready", bad_wready, 0);

    // read with master 0 holding off m_rready for 5 cycles
    do_reset();
    set_c(0, 1, 27'h55);
    bmain_cready = 1;
    cq.push_back({3'b001, 1'b1, 27'h55});
    tick();
    tick();
    m_cvalid[0] = 0;
    bmain_rvalid = 1; bmain_rlast = 1; bmain_rdata = 32'hCAFE0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_rready_held", arb_rready, 0);
      chk("t4_data_held", {arb_grant, m_rvalid, m_rdata}, {3'b001, 3'b001, 32'hCAFE0001});
    end
    rq.push_back({3'b001, 32'hCAFE0001, 1'b1});
    m_rready[0] = 1;
    tick();
    bmain_rvalid = 0;
    chk("t4_idle", arb_grant, 0);
    chk("t4_rq_drained", rq.size(), 0);
    chk("t4_no_hang", arb_hang, 0);

    // reset pulsed in the middle of a write by master 1
    do_reset();
    set_c(1, 0, 27'h77);
    set_w(1, 32'h1111, 4'h3, 0);
    bmain_cready = 1;
    cq.push_back({3'b010, 1'b0, 27'h77});
    tick();
    tick();
    m_cvalid[1] = 0;
    chk("t5_in_wdata", arb_grant, 3'b010);
    reset_n = 0;
    tick();
    bmain_wready = 1; bmain_rvalid = 1; m_rready = '1;
    #1;
    chk("t5_reset_outs", {arb_grant, arb_cvalid, arb_wvalid, arb_rready, m_cready, m_wready, m_rvalid, arb_hang}, 0);
    reset_n = 1;
    bmain_cready = 0; bmain_wready = 0; bmain_rvalid = 0; m_wvalid = '0;
    set_c(0, 1, 27'h1);
    set_c(1, 1, 27'h2);
    tick();
    chk("t5_m0_wins", arb_grant, 3'b001);

    // watchdog: slave never answers a read
    do_reset();
    chk("t6_hang_reset", arb_hang, 0);
    set_c(0, 1, 27'h99);
    m_rready[0] = 1; bmain_cready = 1;
    cq.push_back({3'b001, 1'b1, 27'h99});
    tick();
    chk("t6_cmd_entry", arb_grant, 3'b001);
    tick();
    m_cvalid[0] = 0;
    for (int c = 1; c < 15; c++) tick();
    chk("t6_no_hang_15", arb_hang, 0);
    tick();
    chk("t6_hang_16", arb_hang, 1);
    chk("t6_still_rdata", {arb_grant, arb_rready}, {3'b001, 1'b1});
    tick();
    tick();
    chk("t6_hang_sticky", arb_hang, 1);

    chk("cq_empty", cq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("stray_rready", bad_rr, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
